serial_subtractor: RTL

- Bit-serial inverse of the 4-bit ripple adder: given a sum s (WIDTH+1 bits) and addend a (WIDTH bits), recovers the other operand b = s - a.
- Processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
- Start/busy/done handshake.
- Used to check adder results in loopback benches and as the subtract path for the upcoming ALU.

---
 rtl/serial_subtractor.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers b = s - {0,a} one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   min_q, sub_q, res_q;
    logic [CntW-1:0]  cnt_q;
    logic             borrow_q;
    logic [WIDTH-1:0] b_q;
    logic             err_q, done_q;
    logic             x, y, d, bout, last_bit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_bit = (cnt_q == CntW'(WIDTH));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != StIdle);
        b    = b_q;
        err  = err_q;
        done = done_q;
    end

    // Full-subtractor cell
    always_comb begin
        x    = min_q[0];
        y    = sub_q[0];
        d    = x ^ y ^ borrow_q;
        bout = (~x & y) | (~(x ^ y) & borrow_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_q    <= '0;
            sub_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            b_q      <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        min_q    <= s;
                        sub_q    <= {1'b0, a};
                        res_q    <= '0;
                        cnt_q    <= '0;
                        borrow_q <= 1'b0;
                    end
                end
                StShift: begin
                    // Result fills from the MSB side so bit 0 lands at res_q[0] after WIDTH+1 shifts
                    res_q    <= {d, res_q[WIDTH:1]};
                    min_q    <= min_q >> 1;
                    sub_q    <= sub_q >> 1;
                    borrow_q <= bout;
                    cnt_q    <= cnt_q + 1'b1;
                end
                StDone: begin
                    b_q   <= res_q[WIDTH-1:0];
                    err_q <= borrow_q | res_q[WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule
